// File: rtl/countdown_timer.sv
// Preset-loaded down counter with start/stop/clear pulses, a one-cycle expiry
// strobe, and optional auto-reload of the last preset.
module countdown_timer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic                  start,
  input  logic                  stop,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  running,
  output logic                  done,
  output logic                  expired
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam bit RELOAD_EN = (AUTO_RELOAD != 0);

  state_t                state;
  logic [DATA_WIDTH-1:0] reload;
  logic                  start_ok;
  logic                  decrement;
  logic                  terminal;
  logic                  rearm;

  always_comb begin
    start_ok  = 1'b0;
    decrement = 1'b0;
    terminal  = 1'b0;
    rearm     = 1'b0;
    start_ok  = start && (state == IDLE || state == PAUSED) && (count != '0);
    // A RUN state holding zero only happens in auto-reload, awaiting the reload edge.
    decrement = start_ok || (state == RUN && count != '0);
    terminal  = (count == DATA_WIDTH'(1));
    rearm     = RELOAD_EN && (reload != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        count   <= '0;
        reload  <= '0;
        running <= 1'b0;
        done    <= 1'b0;
      end else if (load) begin
        state   <= IDLE;
        count   <= load_value;
        reload  <= load_value;
        running <= 1'b0;
        done    <= 1'b0;
      end else if (stop) begin
        if (state == RUN) begin
          state   <= PAUSED;
          running <= 1'b0;
        end
      end else if (decrement) begin
        count <= count - DATA_WIDTH'(1);
        if (terminal) begin
          expired <= 1'b1;
          if (rearm) begin
            state   <= RUN;
            running <= 1'b1;
          end else begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end
        end else begin
          state   <= RUN;
          running <= 1'b1;
        end
      end else if (state == RUN) begin
        count <= reload;
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Drives one halting and one auto-reload countdown_timer with shared stimulus and
// checks both against an event-level model every cycle, plus pinned literal cases.
module tb_countdown_timer;

  localparam int unsigned W = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clear = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [W-1:0] load_value = '0;

  logic [W-1:0] count_h, count_a;
  logic         running_h, done_h, expired_h;
  logic         running_a, done_a, expired_a;

  int errors = 0;
  int checks = 0;
  bit compare_en = 1'b0;

  countdown_timer #(.DATA_WIDTH(W), .AUTO_RELOAD(0)) u_halt (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value), .start(start), .stop(stop),
    .count(count_h), .running(running_h), .done(done_h), .expired(expired_h)
  );

  countdown_timer #(.DATA_WIDTH(W), .AUTO_RELOAD(1)) u_auto (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value), .start(start), .stop(stop),
    .count(count_a), .running(running_a), .done(done_a), .expired(expired_a)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          mode;
    int unsigned cnt;
    int unsigned rl;
    bit          exp;
  } mdl_t;

  mdl_t mh = '{M_IDLE, 0, 0, 1'b0};
  mdl_t ma = '{M_IDLE, 0, 0, 1'b0};

  function automatic mdl_t zero_model();
    mdl_t z;
    z.mode = M_IDLE; z.cnt = 0; z.rl = 0; z.exp = 1'b0;
    return z;
  endfunction

  // One running cycle: pending reload, or count one step toward zero.
  function automatic mdl_t run_cycle(mdl_t m, bit ar);
    mdl_t n = m;
    if (m.cnt == 0) begin
      n.cnt = m.rl;
    end else begin
      n.cnt = m.cnt - 1;
      n.mode = M_RUN;
      if (n.cnt == 0) begin
        n.exp = 1'b1;
        if (!(ar && m.rl > 0)) n.mode = M_DONE;
      end
    end
    return n;
  endfunction

  function automatic mdl_t step(mdl_t m, bit ar, bit c, bit l, bit st, bit sp, int unsigned v);
    mdl_t n = m;
    n.exp = 1'b0;
    if (c) n = zero_model();
    else if (l) begin
      n.cnt = v; n.rl = v; n.mode = M_IDLE;
    end else if (sp) begin
      if (m.mode == M_RUN) n.mode = M_PAUSED;
    end else if (st && (m.mode == M_IDLE || m.mode == M_PAUSED) && m.cnt > 0)
      n = run_cycle(n, ar);
    else if (m.mode == M_RUN)
      n = run_cycle(n, ar);
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mh = zero_model();
      ma = zero_model();
    end else begin
      mh = step(mh, 1'b0, clear, load, start, stop, int'(load_value));
      ma = step(ma, 1'b1, clear, load, start, stop, int'(load_value));
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (compare_en) begin
      chk("halt.count",   count_h,   mh.cnt);
      chk("halt.running", running_h, mh.mode == M_RUN);
      chk("halt.done",    done_h,    mh.mode == M_DONE);
      chk("halt.expired", expired_h, mh.exp);
      chk("auto.count",   count_a,   ma.cnt);
      chk("auto.running", running_a, ma.mode == M_RUN);
      chk("auto.done",    done_a,    ma.mode == M_DONE);
      chk("auto.expired", expired_a, ma.exp);
    end
  end

  task automatic tick(input bit c, input bit l, input bit st, input bit sp, input int unsigned v);
    clear = c; load = l; start = st; stop = sp; load_value = W'(v);
    @(posedge clk);
    #1;
    clear = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  initial begin : main
    int unsigned auto_seq [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
    bit          auto_exp [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    int unsigned r;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.count",   count_h,   0);
    chk("reset.running", running_h, 0);
    chk("reset.done",    done_h,    0);
    chk("reset.expired", expired_h, 0);
    reset_n = 1'b1;
    compare_en = 1'b1;

    // Basic run
    tick(0, 1, 0, 0, 5);
    tick(0, 0, 1, 0, 0);
    chk("basic.first", count_h, 4);
    chk("basic.running", running_h, 1);
    idle(3);
    chk("basic.one", count_h, 1);
    chk("basic.pre_exp", expired_h, 0);
    idle(1);
    chk("basic.zero", count_h, 0);
    chk("basic.expired", expired_h, 1);
    chk("basic.done", done_h, 1);
    idle(10);
    chk("basic.hold", count_h, 0);
    chk("basic.exp_low", expired_h, 0);
    chk("basic.done_hold", done_h, 1);

    // Pause and resume
    tick(0, 1, 0, 0, 10);
    tick(0, 0, 1, 0, 0);
    idle(2);
    tick(0, 0, 0, 1, 0);
    chk("pause.count", count_h, 7);
    chk("pause.running", running_h, 0);
    idle(4);
    chk("pause.held", count_h, 7);
    tick(0, 0, 1, 0, 0);
    chk("resume.count", count_h, 6);
    idle(5);
    chk("resume.pre_exp", expired_h, 0);
    idle(1);
    chk("resume.expired", expired_h, 1);
    chk("resume.done", done_h, 1);

    // Priority
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 3);
    tick(0, 0, 1, 1, 0);
    chk("prio.stopstart.count", count_h, 3);
    chk("prio.stopstart.run", running_h, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 1, 0, 1, 8);
    chk("prio.loadstop.count", count_h, 8);
    chk("prio.loadstop.run", running_h, 0);
    tick(1, 1, 0, 0, 8);
    chk("prio.clearload.count", count_h, 0);

    // Auto-reload sequence
    tick(0, 1, 0, 0, 3);
    tick(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) idle(1);
      chk("auto.seq.count", count_a, auto_seq[i]);
      chk("auto.seq.expired", expired_a, auto_exp[i]);
      chk("auto.seq.running", running_a, 1);
      chk("auto.seq.done", done_a, 0);
    end

    // Edge values
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    chk("edge.zero.running", running_h, 0);
    chk("edge.zero.count", count_h, 0);
    tick(0, 1, 0, 0, 1);
    tick(0, 0, 1, 0, 0);
    chk("edge.one.count", count_h, 0);
    chk("edge.one.expired", expired_h, 1);
    chk("edge.one.done", done_h, 1);
    tick(0, 0, 1, 0, 0);
    chk("edge.done_start.done", done_h, 1);
    chk("edge.done_start.exp", expired_h, 0);
    chk("edge.done_start.run", running_h, 0);

    // Asynchronous reset mid-run
    tick(0, 1, 0, 0, 600);
    tick(0, 0, 1, 0, 0);
    idle(99);
    chk("areset.pre", count_h, 500);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset.count", count_h, 0);
    chk("areset.running", running_h, 0);
    chk("areset.done", done_h, 0);
    chk("areset.expired", expired_h, 0);
    chk("areset.auto_count", count_a, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(0, 0, 1, 0, 0);
    chk("areset.start.count", count_h, 0);
    chk("areset.start.running", running_h, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      tick(r < 2, (r >= 2 && r < 8), $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 12));
    end

    compare_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
